// File: rtl/fifo_param_if.sv
// Handshake/data bundle between a FIFO and its producer/consumer.
interface fifo_param_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] d_in;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;
  logic [ADDR_WIDTH:0]   data_count;

  // Producer/consumer side
  modport master (
    output wr_en, rd_en, d_in,
    input  d_out, full, empty, almost_full, almost_empty,
    input  wr_ack, wr_err, rd_ack, rd_err, data_count
  );

  // FIFO side
  modport slave (
    input  wr_en, rd_en, d_in,
    output d_out, full, empty, almost_full, almost_empty,
    output wr_ack, wr_err, rd_ack, rd_err, data_count
  );
endinterface

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with almost-full/almost-empty flags and
// registered per-request handshake flags.
// Define FIFO_FWFT_EN for first-word-fall-through read data; otherwise
// d_out is registered and updates on the edge of an accepted read.
module fifo_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AFULL_TH   = 6,
  parameter int unsigned AEMPTY_TH  = 2
) (
  input  logic         clk,
  input  logic         reset_n,  // active-high asynchronous reset
  fifo_param_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WRITE,
    S_WR_ERR,
    S_READ,
    S_RD_ERR,
    S_RDWR,
    S_RDWR_E   // both requested while empty: write taken, read refused
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] tail;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic is_full_c;
  logic is_empty_c;
  logic wr_ok_c;
  logic rd_ok_c;

  assign is_full_c  = (count == CW'(DEPTH));
  assign is_empty_c = (count == '0);
  // At full a paired read frees the slot the write lands in
  assign wr_ok_c    = bus.wr_en && (!is_full_c || bus.rd_en);
  assign rd_ok_c    = bus.rd_en && !is_empty_c;

  // Next-state decode from the requests and the current occupancy
  always_comb begin
    state_nxt = S_IDLE;
    unique case ({bus.wr_en, bus.rd_en})
      2'b10:   state_nxt = is_full_c  ? S_WR_ERR : S_WRITE;
      2'b01:   state_nxt = is_empty_c ? S_RD_ERR : S_READ;
      2'b11:   state_nxt = is_empty_c ? S_RDWR_E : S_RDWR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) state <= S_INIT;
    else         state <= state_nxt;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_ok_c) tail <= tail + ADDR_WIDTH'(1);
      if (rd_ok_c) head <= head + ADDR_WIDTH'(1);
      if (wr_ok_c && !rd_ok_c)      count <= count + CW'(1);
      else if (rd_ok_c && !wr_ok_c) count <= count - CW'(1);
    end
  end

  // Storage array; contents survive reset and are don't-care afterwards
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[tail] <= bus.d_in;
  end

`ifdef FIFO_FWFT_EN
  // Head word is always visible; zero while nothing is stored
  assign bus.d_out = is_empty_c ? '0 : mem[head];
`else
  logic [DATA_WIDTH-1:0] d_out_q;

  // Registered read data, held between accepted reads
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)      d_out_q <= '0;
    else if (rd_ok_c) d_out_q <= mem[head];
  end

  assign bus.d_out = d_out_q;
`endif

  // Handshake flags are Moore decodes of the registered state
  assign bus.wr_ack = (state == S_WRITE) || (state == S_RDWR) || (state == S_RDWR_E);
  assign bus.wr_err = (state == S_WR_ERR);
  assign bus.rd_ack = (state == S_READ)  || (state == S_RDWR);
  assign bus.rd_err = (state == S_RD_ERR) || (state == S_RDWR_E);

  // Level flags decoded from the registered occupancy
  assign bus.data_count   = count;
  assign bus.full         = is_full_c;
  assign bus.empty        = is_empty_c;
  assign bus.almost_full  = (count >= CW'(AFULL_TH));
  assign bus.almost_empty = (count <= CW'(AEMPTY_TH));

endmodule

// File: tb/tb_fifo_param.sv
// Directed plus randomized checks of fifo_param against a queue-based model.
module tb_fifo_param;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AFT   = 6;
  localparam int unsigned AET   = 2;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_param #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AFULL_TH  (AFT),
    .AEMPTY_TH (AET)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: stored words in arrival order plus last-cycle flags
  logic [31:0] q [$];
  logic [31:0] m_dout;
  bit m_wa, m_we, m_ra, m_re;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    logic [31:0] ed;
    n = q.size();
`ifdef FIFO_FWFT_EN
    ed = (n > 0) ? q[0] : 32'h0;
`else
    ed = m_dout;
`endif
    chk({tag, ".count"},  32'(bus.data_count),   32'(n));
    chk({tag, ".full"},   32'(bus.full),         32'(n == DEPTH));
    chk({tag, ".empty"},  32'(bus.empty),        32'(n == 0));
    chk({tag, ".afull"},  32'(bus.almost_full),  32'(n >= AFT));
    chk({tag, ".aempty"}, 32'(bus.almost_empty), 32'(n <= AET));
    chk({tag, ".wr_ack"}, 32'(bus.wr_ack),       32'(m_wa));
    chk({tag, ".wr_err"}, 32'(bus.wr_err),       32'(m_we));
    chk({tag, ".rd_ack"}, 32'(bus.rd_ack),       32'(m_ra));
    chk({tag, ".rd_err"}, 32'(bus.rd_err),       32'(m_re));
    chk({tag, ".d_out"},  bus.d_out,             ed);
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_wa = 0; m_we = 0; m_ra = 0; m_re = 0;
  endtask

  // One clock of requests, then model update and full comparison
  task automatic step(input bit w, input bit r, input logic [31:0] din, input string tag);
    int n;
    bus.wr_en = w;
    bus.rd_en = r;
    bus.d_in  = din;
    @(posedge clk);
    #1;
    n = q.size();
    m_wa = 0; m_we = 0; m_ra = 0; m_re = 0;
    if (w && r && n == 0) begin
      q.push_back(din);
      m_wa = 1;
      m_re = 1;
    end else begin
      if (r) begin
        if (n > 0) begin m_dout = q.pop_front(); m_ra = 1; end
        else m_re = 1;
      end
      if (w) begin
        if (n < DEPTH || r) begin q.push_back(din); m_wa = 1; end
        else m_we = 1;
      end
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check_all(tag);
  endtask

  // Reset pulse between clock edges; outputs must clear without an edge
  task automatic async_reset(input string tag);
    #2 reset_n = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 reset_n = 1'b0;
  endtask

  initial begin
    bit w, r;
    int pw;
    reset_n   = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.d_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    reset_n = 1'b0;

    // Fill to full, overflow attempt, drain in order, underflow attempt
    for (int i = 1; i <= 8; i++) step(1, 0, 32'(i * 'h11), "fill");
    step(1, 0, 32'h99, "wr_full");
    for (int i = 0; i < 8; i++) step(0, 1, '0, "drain");
    step(0, 1, '0, "rd_empty");
    step(0, 0, '0, "idle");

    // Simultaneous requests mid, full, empty
    for (int i = 0; i < 3; i++) step(1, 0, 32'hA1 + 32'(i), "pre3");
    step(1, 1, 32'hB1, "rdwr_mid");
    for (int i = 0; i < 5; i++) step(1, 0, 32'hC0 + 32'(i), "pre8");
    step(1, 1, 32'hC8, "rdwr_full");
    for (int i = 0; i < 8; i++) step(0, 1, '0, "drain2");
    step(1, 1, 32'hD1, "rdwr_empty");
    step(0, 1, '0, "drain3");

    // Pointer wrap-around
    for (int i = 0; i < 5; i++) step(1, 0, 32'h500 + 32'(i), "wrap_w5");
    for (int i = 0; i < 5; i++) step(0, 1, '0, "wrap_r5");
    for (int i = 0; i < 6; i++) step(1, 0, 32'h600 + 32'(i), "wrap_w6");
    for (int i = 0; i < 6; i++) step(0, 1, '0, "wrap_r6");

    // Asynchronous reset with four words stored
    for (int i = 0; i < 4; i++) step(1, 0, 32'h700 + 32'(i), "pre_rst");
    step(0, 1, '0, "pre_rst_rd");
    step(1, 0, 32'h704, "pre_rst_w");
    async_reset("async_rst");
    step(1, 0, 32'hAB, "post_rst_wr");
    step(0, 1, '0, "post_rst_rd");

    // Randomized traffic, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 800; i++) begin
      pw = ((i / 60) % 2 == 0) ? 75 : 25;
      w  = ($urandom_range(99) < pw);
      r  = ($urandom_range(99) < (100 - pw));
      step(w, r, $urandom, "rand");
      if ($urandom_range(149) == 0) async_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO: next generation of the team's fixed 8x32 FIFO.
- Configurable data width and depth, plus programmable almost-full/almost-empty flags.
- Same registered handshake flags (wr_ack, wr_err, rd_ack, rd_err) as the fixed FIFO, and defined simultaneous read/write at full and empty.
- Sits between producer/consumer datapath blocks as a single-clock elastic buffer.

Parameters:
- DATA_WIDTH, 32, bits per word
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH (legal 2..8)
- AFULL_TH, 6, almost_full asserted when data_count >= AFULL_TH (1..DEPTH-1)
- AEMPTY_TH, 2, almost_empty asserted when data_count <= AEMPTY_TH (1..DEPTH-1)

Ports:
- clk  in  1  clock, rising-edge
- reset_n  in  1  asynchronous, active-high reset (asserted = 1, despite the name)
- wr_en  in  1  write request
- rd_en  in  1  read request
- d_in  in  DATA_WIDTH  write data
- d_out  out  DATA_WIDTH  read data, registered
- full  out  1  data_count == DEPTH
- empty  out  1  data_count == 0
- almost_full  out  1  see AFULL_TH
- almost_empty  out  1  see AEMPTY_TH
- wr_ack  out  1  previous-cycle write accepted
- wr_err  out  1  previous-cycle write rejected
- rd_ack  out  1  previous-cycle read accepted
- rd_err  out  1  previous-cycle read rejected
- data_count  out  ADDR_WIDTH+1  words stored, 0..DEPTH

Behaviour:
- Reset (async, reset_n=1):
  - head, tail, data_count = 0; state = INIT.
  - d_out = 0; all acks/errs = 0.
  - empty = 1, almost_empty = 1; full = 0, almost_full = 0.
  - Memory contents are not cleared and are don't-care.
  - Reset mid-transfer discards all stored data.
- State register (3 bits), next state decoded from wr_en, rd_en and current data_count:
  - INIT: after reset, no request seen yet.
  - IDLE: wr_en = rd_en = 0.
  - WRITE: write only, count < DEPTH.
  - WR_ERR: write only, count == DEPTH.
  - READ: read only, count > 0.
  - RD_ERR: read only, count == 0.
  - RDWR: both requests; a separate flag pattern applies when count == 0 (see Simultaneous requests).
- Accepted write: mem[tail] <= d_in; tail <= tail+1, wrapping mod DEPTH.
- Accepted read: d_out <= mem[head]; head <= head+1, wrapping.
  - Latency: request at edge k → d_out valid after edge k; d_out holds otherwise.
- Simultaneous requests:
  - 0 < count < DEPTH: both accepted, count unchanged.
  - count == DEPTH: read and write both accepted, count stays DEPTH; write slot is the slot freed by the read.
  - count == 0: write accepted, read rejected (rd_err = 1); no read-through of d_in, d_out unchanged.
- data_count: +1 write only, -1 read only, unchanged otherwise; never exceeds DEPTH or goes below 0.
- Flags are Moore outputs of the state, valid for one cycle after the request edge:
  - WRITE → wr_ack
  - WR_ERR → wr_err
  - READ → rd_ack
  - RD_ERR → rd_err
  - RDWR → wr_ack and rd_ack, or wr_ack and rd_err when count was 0
  - IDLE/INIT → all 0
- full, empty, almost_full, almost_empty are decoded combinationally from the registered data_count.
- Rejected operations change no pointer, no count and no memory word.

Optional Feature:
- Macro FIFO_FWFT_EN selects first-word-fall-through mode.
- Defined:
  - d_out presents mem[head] whenever count > 0, and 0 when empty.
  - An accepted rd_en pops the head word; the next word appears after that edge.
  - Read data is available with zero request latency.
  - Flags, count and error rules are unchanged.
- Undefined: registered-read behaviour as above.

Test Plan:
- Reset, then 8 writes 0x11..0x88 → wr_ack each cycle; data_count 1..8; almost_full from count 6; full=1 at 8.
- Write 0x99 when full → wr_err=1, data_count=8, memory unchanged; read 8 → d_out 0x11..0x88 in order, empty=1 at end.
- Read when empty → rd_err=1, d_out unchanged, data_count=0.
- Simultaneous wr/rd:
  - at count 3 → count stays 3, wr_ack=rd_ack=1;
  - at full → count 8, d_out = oldest word, new word stored at the tail;
  - at empty → wr_ack=1, rd_err=1, count 1.
- Wrap-around: 5 writes, 5 reads, 6 writes, 6 reads → data in order, pointers wrap past 7 with no loss.
- reset_n pulsed high mid-stream at count 4 (asynchronous, no clock edge) → immediately count 0, empty=1, flags 0, d_out 0; with FIFO_FWFT_EN, after 1 write of 0xAB, d_out=0xAB before any rd_en.
